fetch_unit_cached: RTL and testbench

- Parametrised instruction-fetch stage with an integrated direct-mapped, line-based instruction cache.
- Holds the PC and selects the next PC: PC+4 or the branch target.
- On a miss, an FSM fetches one line from instruction memory over a req/ready handshake, then refills the cache.
- Adds stall, redirect-during-miss, flush and hit/miss counters.
- Sits between the memory-side instruction store and the decode stage.

---
 rtl/fetch_unit_cached.sv | 129 ++++++++++++
 tb/tb_fetch_unit_cached.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_cached.sv
// Instruction-fetch stage with an integrated direct-mapped, line-based instruction cache.
// A two-state FSM refills one line per miss over a req/ready handshake to instruction memory.
module fetch_unit_cached #(
    parameter int               ADDR_W     = 32,
    parameter int               LINE_WORDS = 4,
    parameter int               SETS       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int               CNT_W      = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     PCSrc,
    input  logic [ADDR_W-1:0]        branchTarget,
    input  logic                     stall,
    input  logic                     flush,
    output logic [31:0]              inst,
    output logic [ADDR_W-1:0]        pcOut,
    output logic                     instValid,
    output logic                     hit,
    output logic                     memReq,
    output logic [ADDR_W-1:0]        memAddr,
    input  logic                     memReady,
    input  logic [32*LINE_WORDS-1:0] memLine,
    output logic [CNT_W-1:0]         hitCount,
    output logic [CNT_W-1:0]         missCount
);

    localparam int WSEL = $clog2(LINE_WORDS);
    localparam int OFF  = WSEL + 2;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_W - IDX - OFF;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MISS_REQ = 1'b1;

    logic [0:0]              state;
    logic                    drop;
    logic                    redirPend;
    logic [ADDR_W-1:0]       redirTarget;

    logic [SETS-1:0]         validQ;
    logic [TAG-1:0]          tagMem  [SETS];
    logic [32*LINE_WORDS-1:0] dataMem [SETS];

    logic [IDX-1:0]          pcIdx;
    logic [TAG-1:0]          pcTag;
    logic [WSEL-1:0]         wordSel;
    logic [32*LINE_WORDS-1:0] lineSel;
    logic [IDX-1:0]          refIdx;
    logic [TAG-1:0]          refTag;
    logic                    refillWe;

    assign pcIdx   = pcOut[OFF+IDX-1:OFF];
    assign pcTag   = pcOut[ADDR_W-1:OFF+IDX];
    assign wordSel = pcOut[OFF-1:2];
    assign lineSel = dataMem[pcIdx];
    assign inst    = lineSel[32*wordSel +: 32];

    assign hit       = (state == RUN) && validQ[pcIdx] && (tagMem[pcIdx] == pcTag);
    assign instValid = hit;

    // The refill target comes from the latched request address, not the PC, which may have moved.
    assign refIdx   = memAddr[OFF+IDX-1:OFF];
    assign refTag   = memAddr[ADDR_W-1:OFF+IDX];
    assign refillWe = (state == MISS_REQ) && memReady && !drop && !flush;

    // NOTE: all state updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= RUN;
            pcOut       <= RESET_PC;
            memReq      <= 1'b0;
            memAddr     <= '0;
            hitCount    <= '0;
            missCount   <= '0;
            redirPend   <= 1'b0;
            redirTarget <= '0;
            drop        <= 1'b0;
            validQ      <= '0;
        end else begin
            if (state == RUN) begin
                if (hit) begin
                    if (!stall) begin
                        pcOut    <= PCSrc ? branchTarget : pcOut + ADDR_W'(4);
                        hitCount <= hitCount + CNT_W'(1);
                    end
                end else begin
                    memAddr   <= {pcOut[ADDR_W-1:OFF], {OFF{1'b0}}};
                    memReq    <= 1'b1;
                    missCount <= missCount + CNT_W'(1);
                    state     <= MISS_REQ;
                end
            end else begin
                if (memReady) begin
                    memReq    <= 1'b0;
                    state     <= RUN;
                    drop      <= 1'b0;
                    redirPend <= 1'b0;
                    // A redirect arriving on the completion cycle wins over an older pending one.
                    if (PCSrc)
                        pcOut <= branchTarget;
                    else if (redirPend)
                        pcOut <= redirTarget;
                end else begin
                    if (PCSrc) begin
                        redirPend   <= 1'b1;
                        redirTarget <= branchTarget;
                    end
                    if (flush)
                        drop <= 1'b1;
                end
            end

            if (flush)
                validQ <= '0;
            else if (refillWe)
                validQ[refIdx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge Clk) begin
        if (refillWe) begin
            tagMem[refIdx]  <= refTag;
            dataMem[refIdx] <= memLine;
        end
    end

endmodule

// File: tb/tb_fetch_unit_cached.sv
// Directed testbench for fetch_unit_cached: a latency-configurable memory responder plus
// per-scenario tasks with hand-computed expectations.
module tb_fetch_unit_cached;

    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int SETS       = 16;
    localparam int CNT_W      = 32;

    logic                     Clk = 1'b0;
    logic                     Rst_n = 1'b0;
    logic                     PCSrc = 1'b0;
    logic [ADDR_W-1:0]        branchTarget = '0;
    logic                     stall = 1'b0;
    logic                     flush = 1'b0;
    logic [31:0]              inst;
    logic [ADDR_W-1:0]        pcOut;
    logic                     instValid;
    logic                     hit;
    logic                     memReq;
    logic [ADDR_W-1:0]        memAddr;
    logic                     memReady;
    logic [32*LINE_WORDS-1:0] memLine;
    logic [CNT_W-1:0]         hitCount;
    logic [CNT_W-1:0]         missCount;

    int nChecks = 0;
    int nFails = 0;
    int memLatency = 3;
    int waitCnt = 0;

    fetch_unit_cached #(
        .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS),
        .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCSrc(PCSrc), .branchTarget(branchTarget),
        .stall(stall), .flush(flush), .inst(inst), .pcOut(pcOut),
        .instValid(instValid), .hit(hit), .memReq(memReq), .memAddr(memAddr),
        .memReady(memReady), .memLine(memLine), .hitCount(hitCount), .missCount(missCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h5A5A_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic logic [32*LINE_WORDS-1:0] mkLine(input logic [31:0] base);
        logic [32*LINE_WORDS-1:0] l;
        l = '0;
        for (int w = 0; w < LINE_WORDS; w++)
            l[w*32 +: 32] = memWord(base + 32'(4*w));
        return l;
    endfunction

    // Instruction-memory responder: answers memLatency negedges after it first sees memReq.
    initial begin
        memReady = 1'b0;
        memLine  = '0;
        forever begin
            @(negedge Clk);
            if (memReady) begin
                memReady = 1'b0;
                waitCnt  = 0;
            end else if (!memReq) begin
                waitCnt = 0;
            end else if (waitCnt >= memLatency) begin
                memLine  = mkLine(memAddr);
                memReady = 1'b1;
            end else begin
                waitCnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic waitHit(input int budget, input string name);
        int n;
        n = 0;
        while (hit !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        nChecks++;
        if (hit !== 1'b1) begin
            nFails++;
            $display("FAIL %s: hit=%b after %0d cycles, required 1", name, hit, budget);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        PCSrc = 1'b1;
        branchTarget = target;
        tick();
        PCSrc = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) tick();
        nChecks++; if (pcOut !== 32'h0) begin nFails++; $display("FAIL reset_pc: got %h required %h", pcOut, 32'h0); end
        nChecks++; if (instValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b required 0", instValid); end
        nChecks++; if (memReq !== 1'b0) begin nFails++; $display("FAIL reset_memreq: got %b required 0", memReq); end
        nChecks++; if (hitCount !== 0 || missCount !== 0) begin nFails++; $display("FAIL reset_counts: got %0d/%0d required 0/0", hitCount, missCount); end
        Rst_n = 1'b1;
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin nFails++; $display("FAIL first_miss: memReq=%b memAddr=%h required 1/00000000", memReq, memAddr); end
        nChecks++; if (instValid !== 1'b0 || missCount !== 1) begin nFails++; $display("FAIL first_miss_state: instValid=%b missCount=%0d required 0/1", instValid, missCount); end
        waitHit(20, "first_refill");
        nChecks++; if (pcOut !== 32'h0 || inst !== 32'h5A5A_0000) begin nFails++; $display("FAIL word0: pc=%h inst=%h required 00000000/5a5a0000", pcOut, inst); end
        for (int i = 1; i < 4; i++) begin
            tick();
            nChecks++;
            if (pcOut !== 32'(4*i) || hit !== 1'b1 || inst !== memWord(32'(4*i))) begin
                nFails++;
                $display("FAIL seq_word%0d: pc=%h hit=%b inst=%h required %h/1/%h", i, pcOut, hit, inst, 32'(4*i), memWord(32'(4*i)));
            end
        end
        tick();
        nChecks++; if (pcOut !== 32'h10 || hit !== 1'b0) begin nFails++; $display("FAIL line_end: pc=%h hit=%b required 00000010/0", pcOut, hit); end
        nChecks++; if (hitCount !== 4 || missCount !== 1) begin nFails++; $display("FAIL first_counts: hit=%0d miss=%0d required 4/1", hitCount, missCount); end
    endtask

    task automatic test_line_cross();
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h10) begin nFails++; $display("FAIL cross_req: memReq=%b memAddr=%h required 1/00000010", memReq, memAddr); end
        waitHit(20, "cross_refill");
        nChecks++; if (pcOut !== 32'h10 || inst !== 32'h5A5A_0010) begin nFails++; $display("FAIL cross_word: pc=%h inst=%h required 00000010/5a5a0010", pcOut, inst); end
        nChecks++; if (missCount !== 2) begin nFails++; $display("FAIL cross_misses: got %0d required 2", missCount); end
    endtask

    task automatic test_redirect_miss();
        int n;
        memLatency = 2;
        redirect(32'h40);
        nChecks++; if (pcOut !== 32'h40 || hit !== 1'b0 || hitCount !== 5) begin nFails++; $display("FAIL rm_branch: pc=%h hit=%b hits=%0d required 00000040/0/5", pcOut, hit, hitCount); end
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h40 || missCount !== 3) begin nFails++; $display("FAIL rm_req: memReq=%b memAddr=%h misses=%0d required 1/00000040/3", memReq, memAddr, missCount); end
        redirect(32'h80);
        n = 0;
        while (pcOut !== 32'h80 && n < 20) begin tick(); n++; end
        nChecks++; if (pcOut !== 32'h80 || hit !== 1'b0) begin nFails++; $display("FAIL rm_pending: pc=%h hit=%b required 00000080/0", pcOut, hit); end
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h80 || missCount !== 4) begin nFails++; $display("FAIL rm_second_req: memReq=%b memAddr=%h misses=%0d required 1/00000080/4", memReq, memAddr, missCount); end
        waitHit(20, "rm_refill80");
        nChecks++; if (inst !== 32'h5A5A_0080) begin nFails++; $display("FAIL rm_word80: got %h required 5a5a0080", inst); end
        redirect(32'h40);
        nChecks++; if (pcOut !== 32'h40 || hit !== 1'b1 || inst !== 32'h5A5A_0040) begin nFails++; $display("FAIL rm_line40_kept: pc=%h hit=%b inst=%h required 00000040/1/5a5a0040", pcOut, hit, inst); end
        nChecks++; if (hitCount !== 6 || missCount !== 4) begin nFails++; $display("FAIL rm_counts: hit=%0d miss=%0d required 6/4", hitCount, missCount); end
    endtask

    task automatic test_branch_stall();
        redirect(32'h8);
        nChecks++; if (pcOut !== 32'h8 || hit !== 1'b1 || hitCount !== 7) begin nFails++; $display("FAIL bs_to8: pc=%h hit=%b hits=%0d required 00000008/1/7", pcOut, hit, hitCount); end
        redirect(32'h40);
        nChecks++; if (pcOut !== 32'h40 || hit !== 1'b1 || hitCount !== 8) begin nFails++; $display("FAIL bs_to40: pc=%h hit=%b hits=%0d required 00000040/1/8", pcOut, hit, hitCount); end
        stall = 1'b1;
        PCSrc = 1'b1;
        branchTarget = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (pcOut !== 32'h40 || instValid !== 1'b1 || hitCount !== 8) begin
                nFails++;
                $display("FAIL bs_stall%0d: pc=%h valid=%b hits=%0d required 00000040/1/8", i, pcOut, instValid, hitCount);
            end
        end
        stall = 1'b0;
        PCSrc = 1'b0;
        tick();
        nChecks++; if (pcOut !== 32'h44 || hitCount !== 9) begin nFails++; $display("FAIL bs_release: pc=%h hits=%0d required 00000044/9", pcOut, hitCount); end
    endtask

    task automatic test_flush_miss();
        memLatency = 2;
        redirect(32'hC0);
        nChecks++; if (hit !== 1'b0 || hitCount !== 10) begin nFails++; $display("FAIL fl_branch: hit=%b hits=%0d required 0/10", hit, hitCount); end
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'hC0 || missCount !== 5) begin nFails++; $display("FAIL fl_req: memReq=%b memAddr=%h misses=%0d required 1/000000c0/5", memReq, memAddr, missCount); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (pcOut !== 32'hC0) begin nFails++; $display("FAIL fl_pc_kept: got %h required 000000c0", pcOut); end
        waitHit(30, "fl_refetch");
        nChecks++; if (pcOut !== 32'hC0 || inst !== 32'h5A5A_00C0) begin nFails++; $display("FAIL fl_word: pc=%h inst=%h required 000000c0/5a5a00c0", pcOut, inst); end
        nChecks++; if (missCount !== 6) begin nFails++; $display("FAIL fl_remiss: misses=%0d required 6", missCount); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (pcOut !== 32'hC4 || hit !== 1'b0 || hitCount !== 11) begin nFails++; $display("FAIL fl_run: pc=%h hit=%b hits=%0d required 000000c4/0/11", pcOut, hit, hitCount); end
        waitHit(30, "fl_run_refill");
        nChecks++; if (inst !== 32'h5A5A_00C4 || missCount !== 7) begin nFails++; $display("FAIL fl_run_word: inst=%h misses=%0d required 5a5a00c4/7", inst, missCount); end
    endtask

    task automatic test_conflict();
        memLatency = 0;
        redirect(32'h000);
        nChecks++; if (hit !== 1'b0) begin nFails++; $display("FAIL cf_0_flushed: hit=%b required 0", hit); end
        waitHit(10, "cf_fill0");
        nChecks++; if (inst !== 32'h5A5A_0000 || missCount !== 8) begin nFails++; $display("FAIL cf_word0: inst=%h misses=%0d required 5a5a0000/8", inst, missCount); end
        redirect(32'h100);
        nChecks++; if (hit !== 1'b0) begin nFails++; $display("FAIL cf_100_miss: hit=%b required 0", hit); end
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h100) begin nFails++; $display("FAIL cf_100_req: memReq=%b memAddr=%h required 1/00000100", memReq, memAddr); end
        tick();
        nChecks++; if (hit !== 1'b1 || inst !== 32'h5A5A_0100) begin nFails++; $display("FAIL cf_min_penalty: hit=%b inst=%h required 1/5a5a0100", hit, inst); end
        redirect(32'h000);
        nChecks++; if (hit !== 1'b0) begin nFails++; $display("FAIL cf_0_replaced: hit=%b required 0", hit); end
        waitHit(10, "cf_refill0");
        nChecks++; if (inst !== 32'h5A5A_0000) begin nFails++; $display("FAIL cf_word0_again: got %h required 5a5a0000", inst); end
        redirect(32'h100);
        nChecks++; if (hit !== 1'b0) begin nFails++; $display("FAIL cf_100_replaced: hit=%b required 0", hit); end
        waitHit(10, "cf_refill100");
        nChecks++; if (missCount !== 11 || hitCount !== 15) begin nFails++; $display("FAIL cf_counts: miss=%0d hit=%0d required 11/15", missCount, hitCount); end
    endtask

    task automatic test_reset_mid_miss();
        memLatency = 20;
        redirect(32'h200);
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h200) begin nFails++; $display("FAIL rmm_req: memReq=%b memAddr=%h required 1/00000200", memReq, memAddr); end
        Rst_n = 1'b0;
        #1;
        nChecks++; if (memReq !== 1'b0 || pcOut !== 32'h0) begin nFails++; $display("FAIL rmm_async: memReq=%b pc=%h required 0/00000000", memReq, pcOut); end
        nChecks++; if (hitCount !== 0 || missCount !== 0 || instValid !== 1'b0) begin nFails++; $display("FAIL rmm_state: hits=%0d misses=%0d valid=%b required 0/0/0", hitCount, missCount, instValid); end
        tick();
        Rst_n = 1'b1;
        tick();
        nChecks++; if (memReq !== 1'b1 || memAddr !== 32'h0 || missCount !== 1) begin nFails++; $display("FAIL rmm_restart: memReq=%b memAddr=%h misses=%0d required 1/00000000/1", memReq, memAddr, missCount); end
        waitHit(40, "rmm_refill");
        nChecks++; if (inst !== 32'h5A5A_0000) begin nFails++; $display("FAIL rmm_word0: got %h required 5a5a0000", inst); end
    endtask

    initial begin
        test_reset();
        test_line_cross();
        test_redirect_miss();
        test_branch_stall();
        test_flush_miss();
        test_conflict();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
